fetch_line_ctrl: RTL and testbench
==================================

Name: fetch_line_ctrl

Overview:
Fetch-side line controller directly upstream of the instruction buffer. It holds the fetch PC and issues one 64-byte (16-instruction) line read per request to the memory arbiter. It delivers each returned line with its aligned base PC and first-valid-slot index as a one-cycle done pulse. It handles redirects by flushing the instruction buffer, retargeting the PC, and discarding any in-flight line.

Parameters:
ADDR_W, 48, fetch/arbiter address width
RESET_PC, 48'h0000_8000_0000, fetch PC after reset
LINE_BYTES, 64, line size; fixed, offset width 6

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
fetch_inst  in  1  refill request pulse from the instruction buffer
redirect_valid  in  1  branch/exception redirect
redirect_target  in  ADDR_W  new fetch PC, 4-byte aligned
can_fetch_inst  out  1  high when in IDLE with no pending request
arb_req  out  1  line read request to the arbiter
arb_addr  out  ADDR_W  64-byte-aligned line address
arb_gnt  in  1  arbiter accepted the request this cycle
arb_done  in  1  line data valid this cycle
arb_rdata  in  512  line data; slot i = bits [32i+31:32i]
pc_operation_done  out  1  one-cycle pulse: new line delivered
pc_read_inst  out  512  registered line data
pc  out  ADDR_W  aligned base PC of the delivered line
first_slot  out  4  index of the first useful instruction, fetch_pc[5:2]
clear_ibuffer  out  1  one-cycle flush pulse to the instruction buffer

Behaviour:
- Reset state:
  - State = IDLE, fetch_pc = RESET_PC, pending = 1, so the first fetch issues automatically.
  - Outputs: arb_req = 0, pc_operation_done = 0, clear_ibuffer = 0, pc_read_inst = 0, pc = 0, first_slot = 0.
  - Reset mid-transaction abandons it. The arbiter is reset by the same signal.
- pending flag:
  - Set by fetch_inst in any state, and by redirect.
  - Cleared on the IDLE -> REQ transition.
- State machine:
  - IDLE: if pending (or fetch_inst this cycle), go to REQ next cycle. arb_addr = {fetch_pc[47:6], 6'b0}.
  - REQ: arb_req = 1, arb_addr stable. On arb_gnt, go to WAIT.
  - WAIT: on arb_done, register arb_rdata -> pc_read_inst, arb_addr -> pc, and fetch_pc[5:2] -> first_slot. pc_operation_done = 1 the next cycle. fetch_pc <= aligned base + 64. Go to IDLE.
  - DISCARD: on arb_done, drop the data and go to IDLE. No done pulse.
- Latency:
  - fetch_inst in IDLE at cycle t -> arb_req at t+1.
  - arb_done at cycle d -> pc_operation_done at d+1.
  - arb_done is never asserted in the same cycle as arb_gnt.
- Sequential fetch: after the first line, fetch_pc is line-aligned, so first_slot = 0.
- Redirect, any state:
  - clear_ibuffer pulses the next cycle; fetch_pc <= redirect_target; pending <= 1.
  - IDLE -> IDLE.
  - REQ without arb_gnt the same cycle: deassert arb_req next cycle, go to IDLE (request withdrawn; the arbiter permits this).
  - REQ with arb_gnt the same cycle -> DISCARD.
  - WAIT -> DISCARD.
  - WAIT with arb_done the same cycle: redirect wins, data dropped, no done pulse, go to IDLE.
  - DISCARD: stay, and latch the newest target.
- Width rules:
  - PC addition is modulo 2^48; no wrap detection.
  - redirect_target[1:0] is ignored (treated as 0).
- Multiple fetch_inst pulses while busy collapse into one pending request.
- The done pulse never coincides with clear_ibuffer for the same transaction.

Decomposition:
- Package fetch_pkg holds:
  - state enum {IDLE, REQ, WAIT, DISCARD}
  - LINE_OFF_W = 6
  - SLOT_W = 4
  - RESET_PC
  - a line-align helper function
- No sub-module; the FSM, PC register and output registers fit in one module.

Test Plan:
- Reset release -> arb_req at the first posedge after release; arb_addr = 0x0000_8000_0000. arb_gnt, then arb_done 3 cycles later with pattern data -> done pulse; pc = 0x8000_0000, first_slot = 0, pc_read_inst matches.
- fetch_inst after the first line -> arb_addr = 0x8000_0040; after the second done, pc = 0x8000_0040.
- Redirect to 0x8000_1234 while in WAIT -> clear_ibuffer pulse. The old arb_done is dropped with no done pulse. Next arb_addr = 0x8000_1200; on delivery, first_slot = 13.
- Redirect during REQ before grant -> arb_req drops for ≥1 cycle, then reasserts with the new aligned address. Redirect in the same cycle as arb_gnt -> DISCARD, response dropped.
- Three fetch_inst pulses during WAIT -> exactly one further request after done; can_fetch_inst = 0 until it completes.
- Redirect in the same cycle as arb_done -> no pc_operation_done; clear_ibuffer = 1; refetch from the target.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, state encoding and line-align helper for the fetch line controller
package fetch_pkg;
    localparam int ADDR_W = 48;
    localparam int LINE_BYTES = 64;
    localparam int LINE_OFF_W = 6;
    localparam int SLOT_W = 4;
    localparam logic [ADDR_W-1:0] RESET_PC = 48'h0000_8000_0000;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_REQ = 2'd1;
    localparam state_t S_WAIT = 2'd2;
    localparam state_t S_DISCARD = 2'd3;
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    endfunction
endpackage

// File: rtl/fetch_line_ctrl.sv
// fetch_line_ctrl: holds the fetch PC, issues one 64-byte line read per request, delivers lines, handles redirects
// Ports: clock/reset_n (async active-low); fetch_inst, redirect_valid/redirect_target from the front end;
// arb_req/arb_addr/arb_gnt/arb_done/arb_rdata to the memory arbiter; can_fetch_inst, pc_operation_done,
// pc_read_inst, pc, first_slot, clear_ibuffer to the instruction buffer.
module fetch_line_ctrl
    import fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fetch_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              can_fetch_inst,
    output logic              arb_req,
    output logic [ADDR_W-1:0] arb_addr,
    input  logic              arb_gnt,
    input  logic              arb_done,
    input  logic [511:0]      arb_rdata,
    output logic              pc_operation_done,
    output logic [511:0]      pc_read_inst,
    output logic [ADDR_W-1:0] pc,
    output logic [SLOT_W-1:0] first_slot,
    output logic              clear_ibuffer
);
    state_t            state, state_d;
    logic              pending;
    logic [ADDR_W-1:0] fetch_pc;
    logic              deliver;

    assign arb_addr       = line_align(fetch_pc);
    assign arb_req        = state == S_REQ;
    assign can_fetch_inst = state == S_IDLE && !pending;
    assign deliver        = state == S_WAIT && arb_done && !redirect_valid;

    // A redirect that cannot withdraw cleanly (granted or in flight) parks in DISCARD until the stale line returns.
    always_comb begin
        state_d = redirect_valid ?
                      (state == S_IDLE ? S_IDLE :
                       state == S_REQ  ? (arb_gnt ? S_DISCARD : S_IDLE) :
                       (arb_done ? S_IDLE : S_DISCARD)) :
                  state == S_IDLE ? ((pending || fetch_inst) ? S_REQ : S_IDLE) :
                  state == S_REQ  ? (arb_gnt ? S_WAIT : S_REQ) :
                  (arb_done ? S_IDLE : state);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            pending           <= 1'b1;
            fetch_pc          <= RESET_PC;
            pc_operation_done <= 1'b0;
            pc_read_inst      <= '0;
            pc                <= '0;
            first_slot        <= '0;
            clear_ibuffer     <= 1'b0;
        end else begin
            state             <= state_d;
            pending           <= redirect_valid ? 1'b1 :
                                 (state == S_IDLE && (pending || fetch_inst)) ? 1'b0 :
                                 (pending || fetch_inst);
            pc_operation_done <= deliver;
            clear_ibuffer     <= redirect_valid;
            if (redirect_valid)
                fetch_pc <= {redirect_target[ADDR_W-1:2], 2'b00};
            else if (deliver)
                fetch_pc <= arb_addr + ADDR_W'(LINE_BYTES);
            if (deliver) begin
                pc_read_inst <= arb_rdata;
                pc           <= arb_addr;
                first_slot   <= fetch_pc[LINE_OFF_W-1:2];
            end
        end
    end
endmodule

// File: tb/tb_fetch_line_ctrl.sv
// tb_fetch_line_ctrl: directed self-checking bench for fetch_line_ctrl
module tb_fetch_line_ctrl;
    logic         clock = 1'b0;
    logic         reset_n;
    logic         fetch_inst, redirect_valid, arb_gnt, arb_done;
    logic [47:0]  redirect_target;
    logic         can_fetch_inst, arb_req, pc_operation_done, clear_ibuffer;
    logic [47:0]  arb_addr, pc;
    logic [511:0] arb_rdata, pc_read_inst;
    logic [3:0]   first_slot;
    int           vectors = 0;
    int           miscompares = 0;

    fetch_line_ctrl dut (
        .clock(clock), .reset_n(reset_n), .fetch_inst(fetch_inst),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .can_fetch_inst(can_fetch_inst), .arb_req(arb_req), .arb_addr(arb_addr),
        .arb_gnt(arb_gnt), .arb_done(arb_done), .arb_rdata(arb_rdata),
        .pc_operation_done(pc_operation_done), .pc_read_inst(pc_read_inst),
        .pc(pc), .first_slot(first_slot), .clear_ibuffer(clear_ibuffer)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pattern(input logic [7:0] seed);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = {seed, 8'(i), ~seed, 8'(i * 3)};
        return d;
    endfunction

    task automatic grant_and_return(input logic [511:0] data);
        arb_gnt = 1'b1;
        tick();
        arb_gnt = 1'b0;
        arb_done = 1'b1;
        arb_rdata = data;
        tick();
        arb_done = 1'b0;
    endtask

    task automatic redirect(input logic [47:0] t);
        redirect_valid = 1'b1;
        redirect_target = t;
    endtask

    initial begin
        reset_n = 1'b0;
        fetch_inst = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        arb_gnt = 1'b0;
        arb_done = 1'b0;
        arb_rdata = '0;
        tick();
        tick();
        chk("rst_arb_req", 512'(arb_req), 512'(0));
        chk("rst_done", 512'(pc_operation_done), 512'(0));
        chk("rst_clear", 512'(clear_ibuffer), 512'(0));
        chk("rst_pc", 512'(pc), 512'(0));
        chk("rst_first_slot", 512'(first_slot), 512'(0));
        chk("rst_rdata", pc_read_inst, 512'(0));
        chk("rst_can_fetch", 512'(can_fetch_inst), 512'(0));
        reset_n = 1'b1;
        tick();
        chk("boot_req", 512'(arb_req), 512'(1));
        chk("boot_addr", 512'(arb_addr), 512'(48'h0000_8000_0000));
        arb_gnt = 1'b1;
        tick();
        arb_gnt = 1'b0;
        chk("boot_req_drop", 512'(arb_req), 512'(0));
        tick();
        tick();
        arb_done = 1'b1;
        arb_rdata = pattern(8'hA1);
        tick();
        arb_done = 1'b0;
        chk("boot_done", 512'(pc_operation_done), 512'(1));
        chk("boot_pc", 512'(pc), 512'(48'h0000_8000_0000));
        chk("boot_slot", 512'(first_slot), 512'(0));
        chk("boot_data", pc_read_inst, pattern(8'hA1));
        chk("boot_can_fetch", 512'(can_fetch_inst), 512'(1));
        tick();
        chk("boot_done_pulse", 512'(pc_operation_done), 512'(0));

        fetch_inst = 1'b1;
        tick();
        fetch_inst = 1'b0;
        chk("seq_req", 512'(arb_req), 512'(1));
        chk("seq_addr", 512'(arb_addr), 512'(48'h0000_8000_0040));
        grant_and_return(pattern(8'hB2));
        chk("seq_done", 512'(pc_operation_done), 512'(1));
        chk("seq_pc", 512'(pc), 512'(48'h0000_8000_0040));
        chk("seq_data", pc_read_inst, pattern(8'hB2));

        fetch_inst = 1'b1;
        tick();
        fetch_inst = 1'b0;
        arb_gnt = 1'b1;
        tick();
        arb_gnt = 1'b0;
        redirect(48'h0000_8000_1234);
        tick();
        redirect_valid = 1'b0;
        chk("rw_clear", 512'(clear_ibuffer), 512'(1));
        chk("rw_req", 512'(arb_req), 512'(0));
        arb_done = 1'b1;
        arb_rdata = pattern(8'hEE);
        tick();
        arb_done = 1'b0;
        chk("rw_no_done", 512'(pc_operation_done), 512'(0));
        chk("rw_clear_pulse", 512'(clear_ibuffer), 512'(0));
        tick();
        chk("rw_refetch_req", 512'(arb_req), 512'(1));
        chk("rw_refetch_addr", 512'(arb_addr), 512'(48'h0000_8000_1200));
        grant_and_return(pattern(8'hC3));
        chk("rw_done", 512'(pc_operation_done), 512'(1));
        chk("rw_pc", 512'(pc), 512'(48'h0000_8000_1200));
        chk("rw_slot", 512'(first_slot), 512'(13));
        chk("rw_data", pc_read_inst, pattern(8'hC3));

        fetch_inst = 1'b1;
        tick();
        fetch_inst = 1'b0;
        chk("rq_addr", 512'(arb_addr), 512'(48'h0000_8000_1240));
        redirect(48'h0000_8000_2000);
        tick();
        redirect_valid = 1'b0;
        chk("rq_withdrawn", 512'(arb_req), 512'(0));
        chk("rq_clear", 512'(clear_ibuffer), 512'(1));
        tick();
        chk("rq_reissue", 512'(arb_req), 512'(1));
        chk("rq_new_addr", 512'(arb_addr), 512'(48'h0000_8000_2000));

        redirect(48'h0000_8000_3008);
        arb_gnt = 1'b1;
        tick();
        redirect_valid = 1'b0;
        arb_gnt = 1'b0;
        chk("rg_req", 512'(arb_req), 512'(0));
        chk("rg_clear", 512'(clear_ibuffer), 512'(1));
        arb_done = 1'b1;
        arb_rdata = pattern(8'hDD);
        tick();
        arb_done = 1'b0;
        chk("rg_no_done", 512'(pc_operation_done), 512'(0));
        tick();
        chk("rg_addr", 512'(arb_addr), 512'(48'h0000_8000_3000));
        arb_gnt = 1'b1;
        tick();
        arb_gnt = 1'b0;

        for (int i = 0; i < 6; i++) begin
            fetch_inst = (i % 2 == 0);
            tick();
        end
        fetch_inst = 1'b0;
        chk("multi_can_fetch", 512'(can_fetch_inst), 512'(0));
        arb_done = 1'b1;
        arb_rdata = pattern(8'h44);
        tick();
        arb_done = 1'b0;
        chk("multi_done", 512'(pc_operation_done), 512'(1));
        chk("multi_pc", 512'(pc), 512'(48'h0000_8000_3000));
        chk("multi_slot", 512'(first_slot), 512'(2));
        chk("multi_busy", 512'(can_fetch_inst), 512'(0));
        tick();
        chk("multi_req", 512'(arb_req), 512'(1));
        chk("multi_addr", 512'(arb_addr), 512'(48'h0000_8000_3040));
        grant_and_return(pattern(8'h55));
        chk("multi_done2", 512'(pc_operation_done), 512'(1));
        tick();
        chk("multi_single", 512'(arb_req), 512'(0));
        chk("multi_idle", 512'(can_fetch_inst), 512'(1));

        fetch_inst = 1'b1;
        tick();
        fetch_inst = 1'b0;
        arb_gnt = 1'b1;
        tick();
        arb_gnt = 1'b0;
        arb_done = 1'b1;
        arb_rdata = pattern(8'h66);
        redirect(48'h0000_8000_4007);
        tick();
        arb_done = 1'b0;
        redirect_valid = 1'b0;
        chk("rd_no_done", 512'(pc_operation_done), 512'(0));
        chk("rd_clear", 512'(clear_ibuffer), 512'(1));
        tick();
        chk("rd_addr", 512'(arb_addr), 512'(48'h0000_8000_4000));
        grant_and_return(pattern(8'h77));
        chk("rd_pc", 512'(pc), 512'(48'h0000_8000_4000));
        chk("rd_slot", 512'(first_slot), 512'(1));

        redirect(48'hFFFF_FFFF_FFC4);
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_addr", 512'(arb_addr), 512'(48'hFFFF_FFFF_FFC0));
        grant_and_return(pattern(8'h88));
        chk("wrap_slot", 512'(first_slot), 512'(1));
        fetch_inst = 1'b1;
        tick();
        fetch_inst = 1'b0;
        chk("wrap_next_addr", 512'(arb_addr), 512'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
